// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The HALT state exists only when FETCH_MISALIGN_CHECK_EN is defined.
package fetch_pkg;

  localparam int PC_W = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    HALT  = 2'd2
`endif
  } state_t;

  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue: DEPTH-entry synchronous FIFO with flush.
// Storage is not reset; only the pointers and occupancy are.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= ptr_inc(wptr);
      if (do_pop)  rptr <= ptr_inc(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Credit-based instruction fetch with in-order memory responses and redirect drain.
// Define FETCH_MISALIGN_CHECK_EN to add the misaligned-target HALT state and ins_misalign.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            ins_valid,
  input  logic            ins_ready,
  output logic [31:0]     ins,
  output logic [PC_W-1:0] ins_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            ins_misalign
`endif
);
  localparam int CW = $clog2(QDEPTH + 1);

  state_t          state;
  logic [PC_W-1:0] pc, rsp_pc, tgt;
  logic [CW-1:0]   inflight, drop, drop_new, fifo_count;
  logic            req_hold, req_fire, credit_ok, pop, push;
  logic            fifo_full, fifo_empty;
  logic [63:0]     fifo_rdata;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            tgt_mis, halt_pend;

  assign tgt     = redirect_pc;
  assign tgt_mis = |redirect_pc[1:0];
`else
  assign tgt     = redirect_pc & ~PC_W'(3);
`endif

  // A slot freed by this cycle's pop can be re-requested immediately.
  assign credit_ok = (int'(inflight) + int'(fifo_count) - int'(pop)) < QDEPTH;
  assign imem_req_valid = rst_n && (state == RUN) && (req_hold || credit_ok);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign pop  = ins_valid && ins_ready && (state == RUN);
  assign push = imem_rsp_valid && (state == RUN) && !redirect_valid && (!fifo_full || pop);

  // Responses still owed by memory that must be thrown away after a redirect.
  assign drop_new = ((state == DRAIN) ? drop : inflight) + CW'(req_fire) - CW'(imem_rsp_valid);

  fetch_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (push),
    .wdata ({rsp_pc, imem_rsp_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    ins_valid = 1'b0;
    ins       = '0;
    ins_pc    = '0;
    if (state == RUN && !fifo_empty) begin
      ins_valid = 1'b1;
      ins       = fifo_rdata[31:0];
      ins_pc    = fifo_rdata[63:32];
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    ins_misalign = 1'b0;
    if (state == HALT) begin
      ins_valid    = 1'b1;
      ins          = NOP;
      ins_pc       = pc;
      ins_misalign = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      pc        <= RESET_PC;
      rsp_pc    <= RESET_PC;
      inflight  <= '0;
      drop      <= '0;
      req_hold  <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      halt_pend <= 1'b0;
`endif
    end else begin
      // An offered request stays up until taken so its address cannot change.
      req_hold <= imem_req_valid && !imem_req_ready && !redirect_valid;
      if (redirect_valid) begin
        pc       <= tgt;
        rsp_pc   <= tgt;
        inflight <= '0;
        drop     <= drop_new;
`ifdef FETCH_MISALIGN_CHECK_EN
        halt_pend <= tgt_mis;
        state     <= (drop_new != '0) ? DRAIN : (tgt_mis ? HALT : RUN);
`else
        state     <= (drop_new != '0) ? DRAIN : RUN;
`endif
      end else begin
        case (state)
          RUN: begin
            if (req_fire) pc <= next_pc(pc);
            if (push)     rsp_pc <= next_pc(rsp_pc);
            inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
          end
          DRAIN: begin
            if (imem_rsp_valid) begin
              drop <= drop - CW'(1);
              if (drop == CW'(1)) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                state <= halt_pend ? HALT : RUN;
`else
                state <= RUN;
`endif
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a program-order reference model.
module tb_fetch_unit;
  localparam int QDEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ins_valid, ins_ready;
  logic [31:0] ins, ins_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        ins_misalign;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins            (ins),
    .ins_pc         (ins_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .ins_misalign   (ins_misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mq[$];
  int          n_assert = 0, n_fail = 0;
  int          cyc = 0, lat_lo = 0, lat_hi = 0;
  int          hs_cnt = 0, req_cnt = 0;
  logic [31:0] exp_pc, last_hs_pc, last_req, prev_addr;
  logic        prev_stall, halt_mode;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] eff_target(input logic [31:0] p);
`ifdef FETCH_MISALIGN_CHECK_EN
    return p;
`else
    return {p[31:2], 2'b00};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, update model, then drive memory response after the edge.
  task automatic step();
    mreq_t m;
    @(negedge clk);
    if (prev_stall) begin
      chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
      chk("req_hold_addr", imem_req_addr, prev_addr);
    end
    prev_stall = imem_req_valid && !imem_req_ready && !redirect_valid;
    prev_addr  = imem_req_addr;
    if (imem_req_valid && imem_req_ready) begin
      chk("req_align", 32'(imem_req_addr[1:0]), 32'd0);
      chk("req_seq", imem_req_addr, last_req + 32'd4);
      last_req = imem_req_addr;
      req_cnt++;
      m.addr = imem_req_addr;
      m.due  = cyc + 1 + int'($urandom_range(lat_hi, lat_lo));
      mq.push_back(m);
      chk("credit", 32'(mq.size() <= QDEPTH), 32'd1);
    end
    if (ins_valid && ins_ready && !halt_mode) begin
      chk("ins_pc", ins_pc, exp_pc);
      chk("ins_data", ins, memfn(exp_pc));
      last_hs_pc = ins_pc;
      hs_cnt++;
      exp_pc = exp_pc + 32'd4;
    end
    if (redirect_valid) begin
      exp_pc   = eff_target(redirect_pc);
      last_req = exp_pc - 32'd4;
`ifdef FETCH_MISALIGN_CHECK_EN
      halt_mode = (redirect_pc[1:0] != 2'b00);
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      m = mq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memfn(m.addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    mq.delete();
    prev_stall = 1'b0;
    halt_mode  = 1'b0;
    exp_pc     = RESET_PC;
    last_req   = RESET_PC - 32'd4;
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_ins_valid", 32'(ins_valid), 32'd0);
    chk("rst_ins", ins, 32'd0);
    chk("rst_ins_pc", ins_pc, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_misalign", 32'(ins_misalign), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_hs(input string tag, input logic [31:0] pc);
    int h0, n;
    h0 = hs_cnt;
    n  = 0;
    while (hs_cnt == h0 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_seen"}, 32'(hs_cnt != h0), 32'd1);
    chk(tag, last_hs_pc, pc);
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int h0, r0, n;
    imem_req_ready = 1'b1;
    ins_ready      = 1'b1;
    last_hs_pc     = '0;

    // Streaming from reset with a single-cycle memory.
    do_reset();
    #1;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, RESET_PC);
    repeat (5) step();
    h0 = hs_cnt;
    repeat (10) step();
    chk("throughput", 32'(hs_cnt - h0), 32'd10);

    // Decode stalled from reset: credits cap outstanding work.
    ins_ready = 1'b0;
    do_reset();
    r0 = req_cnt;
    repeat (10) step();
    chk("stall_reqs", 32'(req_cnt - r0), 32'(QDEPTH));
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    ins_ready = 1'b1;
    wait_hs("stall_release_first", RESET_PC);
    repeat (10) step();

    // Redirect with two responses outstanding.
    lat_lo = 2; lat_hi = 2;
    n = 0;
    while ((mq.size() + int'(imem_rsp_valid)) != 2 && n < 30) begin
      step();
      n++;
    end
    chk("two_inflight", 32'(mq.size() + int'(imem_rsp_valid)), 32'd2);
    redirect_to(32'h0000_0100);
    chk("drain_ins_valid", 32'(ins_valid), 32'd0);
    wait_hs("redir_first_pc", 32'h0000_0100);

    // Redirect coinciding with a response and an instruction handshake.
    lat_lo = 1; lat_hi = 1;
    n = 0;
    while (!(imem_rsp_valid && ins_valid) && n < 30) begin
      step();
      n++;
    end
    chk("coinc_found", 32'(imem_rsp_valid && ins_valid), 32'd1);
    h0 = hs_cnt;
    redirect_to(32'h0000_0300);
    chk("coinc_hs_once", 32'(hs_cnt - h0), 32'd1);
    wait_hs("coinc_next_pc", 32'h0000_0300);
    wait_hs("coinc_second_pc", 32'h0000_0304);

    // Address wrap at the top of the space.
    lat_lo = 0; lat_hi = 0;
    redirect_to(32'hFFFF_FFF8);
    wait_hs("wrap_a", 32'hFFFF_FFF8);
    wait_hs("wrap_b", 32'hFFFF_FFFC);
    wait_hs("wrap_c", 32'h0000_0000);

    // Misaligned redirect target.
    redirect_to(32'h0000_0102);
`ifdef FETCH_MISALIGN_CHECK_EN
    repeat (6) step();
    chk("halt_valid", 32'(ins_valid), 32'd1);
    chk("halt_misalign", 32'(ins_misalign), 32'd1);
    chk("halt_ins", ins, 32'h0000_0013);
    chk("halt_pc", ins_pc, 32'h0000_0102);
    r0 = req_cnt;
    repeat (8) step();
    chk("halt_no_req", 32'(req_cnt - r0), 32'd0);
    redirect_to(32'h0000_0200);
    wait_hs("halt_resume", 32'h0000_0200);
    chk("resume_misalign", 32'(ins_misalign), 32'd0);
`else
    wait_hs("forced_align", 32'h0000_0100);
`endif

    // Randomized traffic with back-pressure, variable latency and redirects.
    lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 500; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      ins_ready      = ($urandom_range(3, 0) != 0);
      if ($urandom_range(39, 0) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom & 32'h0000_3FFC;
      end
      step();
    end
    imem_req_ready = 1'b1;
    ins_ready      = 1'b1;
    redirect_to(32'h0000_0400);
    wait_hs("final_pc", 32'h0000_0400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: QDEPTH, 2, instruction-queue entries and maximum in-flight credits (legal 2..8).
REQ-003 Port: clk  in  1  single clock, all state on rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: imem_req_valid  out  1  fetch request valid.
REQ-006 Port: imem_req_ready  in  1  memory accepts request.
REQ-007 Port: imem_req_addr  out  32  fetch address (word-aligned).
REQ-008 Port: imem_rsp_valid  in  1  response valid; responses return in request order, never back-pressured.
REQ-009 Port: imem_rsp_data  in  32  fetched instruction word.
REQ-010 Port: redirect_valid  in  1  branch/jump redirect, single-cycle pulse.
REQ-011 Port: redirect_pc  in  32  redirect target.
REQ-012 Port: ins_valid  out  1  instruction available to the decode stage.
REQ-013 Port: ins_ready  in  1  decode accepts instruction.
REQ-014 Port: ins  out  32  instruction word to the field splitter/decoder.
REQ-015 Port: ins_pc  out  32  address of ins.
REQ-016 Port: ins_misalign  out  1  misaligned-target flag (present only with FETCH_MISALIGN_CHECK_EN).

Function
REQ-017 FSM states RUN, DRAIN, HALT; HALT exists only with FETCH_MISALIGN_CHECK_EN.
REQ-018 RUN: imem_req_valid=1 when in-flight + queue occupancy < QDEPTH; imem_req_addr=pc.
REQ-019 Request accepted (valid&ready) -> pc <= pc+4, in-flight +1; 32'hFFFF_FFFC wraps to 0.
REQ-020 Response -> {data, address} pushed to queue, in-flight -1; ins_valid visible next cycle (rsp cycle N -> ins_valid N+1).
REQ-021 Queue never overflows (credit rule REQ-018); a response arriving with a full queue is impossible by construction.
REQ-022 ins/ins_pc = queue head; pop on ins_valid&ins_ready; simultaneous push and pop allowed at full or empty.
REQ-023 Request address held stable while imem_req_valid=1 and imem_req_ready=0.
REQ-024 Redirect: queue flushed, pc <= redirect_pc, drop counter <= in-flight (plus request accepted same cycle); go DRAIN if drop counter nonzero, else RUN.
REQ-025 Redirect same cycle as ins handshake: handshake completes, then flush.
REQ-026 Redirect same cycle as response: that response is discarded and counted against the drop counter.
REQ-027 DRAIN: imem_req_valid=0, ins_valid=0; each response decrements drop counter and is discarded; at zero -> RUN.
REQ-028 Redirect during DRAIN: pc replaced, drop counter keeps counting remaining in-flight, stay DRAIN.

Reset
REQ-029 On rst_n low: pc=RESET_PC, state RUN, queue empty, in-flight=0, drop counter=0.
REQ-030 Outputs during reset: imem_req_valid=0, ins_valid=0, ins=0, ins_pc=0, ins_misalign=0; requests begin first edge after release.
REQ-031 Reset mid-transaction discards all in-flight bookkeeping; memory is reset together with this block.

Configuration
REQ-032 Macro FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 -> HALT after any DRAIN; ins_valid=1, ins=32'h0000_0013, ins_pc=target, ins_misalign=1, no requests; only next redirect leaves HALT.
REQ-033 Macro undefined: ins_misalign port absent, redirect_pc[1:0] forced to 2'b00, no HALT state.

Structure
REQ-034 Package fetch_pkg holds FSM state enum, NOP constant 32'h0000_0013, PC width constant.
REQ-035 Sub-module fetch_fifo: QDEPTH-entry 64-bit synchronous FIFO with flush, push, pop, full, empty, count.

Verification
REQ-036 Reset release, imem_req_ready=1, 1-cycle memory, ins_ready=1 -> addresses 0,4,8...; ins_pc matches; one instruction per cycle steady state.
REQ-037 ins_ready=0 for 10 cycles -> exactly QDEPTH requests issued then imem_req_valid=0; no lost or duplicated words on release.
REQ-038 Redirect to 32'h0000_0100 with 2 in-flight -> both late responses dropped; first ins after redirect has ins_pc=0x100.
REQ-039 redirect_valid coinciding with imem_rsp_valid and ins handshake -> handshaked word consumed once, response discarded, DRAIN exits correctly.
REQ-040 pc=32'hFFFF_FFFC fetch -> next request address 0x0000_0000.
REQ-041 With macro: redirect to 32'h0000_0102 -> ins_misalign=1, ins=0x00000013, no requests until redirect to 0x200 resumes fetch.
